// File: rtl/shift_sub_div.sv
// shift_sub_div: sequential restoring divider, one quotient bit per clock.
// Ports: clk, n_rst (sync active-low), start, dividend, divisor -> busy, done,
// quotient, remainder, dbz. Define SHIFT_SUB_DIV_SIGNED_EN for two's complement.
module shift_sub_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] div_s;
  logic [CW-1:0]    cnt;
  // divide-by-zero result is published one edge after acceptance
  logic             pend;

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;

`ifdef SHIFT_SUB_DIV_SIGNED_EN
  logic sgn_a;
  logic sgn_b;

  always_comb begin
    ld_a = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    ld_b = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    fin_q = (sgn_a ^ sgn_b) ? (~quo_n + 1'b1) : quo_n;
    fin_r = sgn_a ? (~rem_n[WIDTH-1:0] + 1'b1) : rem_n[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sgn_a <= 1'b0;
      sgn_b <= 1'b0;
    end else if (state == S_IDLE && !pend && start) begin
      sgn_a <= dividend[WIDTH-1];
      sgn_b <= divisor[WIDTH-1];
    end
  end
`else
  always_comb begin
    ld_a  = dividend;
    ld_b  = divisor;
    fin_q = quo_n;
    fin_r = rem_n[WIDTH-1:0];
  end
`endif

  // Shift {rem_s,quo_s} left and try subtracting the divisor.
  // A set guard bit means the shifted value already exceeds the divisor.
  always_comb begin
    sh    = {rem_s[WIDTH-1:0], quo_s[WIDTH-1]};
    diff  = {1'b0, sh} - {2'b00, div_s};
    ge    = rem_s[WIDTH] | ~diff[WIDTH+1];
    rem_n = ge ? diff[WIDTH:0] : sh;
    quo_n = {quo_s[WIDTH-2:0], ge};
  end

  // cnt is still 0 in the first BUSY cycle, so busy spans edges k+1..k+WIDTH-1
  assign busy = (state == S_BUSY) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      rem_s     <= '0;
      quo_s     <= '0;
      div_s     <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pend) begin
            pend      <= 1'b0;
            done      <= 1'b1;
            dbz       <= 1'b1;
            quotient  <= '1;
            remainder <= quo_s;
          end else if (start) begin
            if (divisor == '0) begin
              pend  <= 1'b1;
              quo_s <= dividend;
            end else begin
              quo_s <= ld_a;
              div_s <= ld_b;
              rem_s <= '0;
              cnt   <= '0;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_s <= rem_n;
          quo_s <= quo_n;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            quotient  <= fin_q;
            remainder <= fin_r;
            done      <= 1'b1;
            dbz       <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_div.sv
// tb_shift_sub_div: self-checking bench for shift_sub_div (WIDTH=8).
// Directed and random operands compared against a plain arithmetic model.
module tb_shift_sub_div;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;

  int checks;
  int failures;

  shift_sub_div #(.WIDTH(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the arithmetic definition.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic z);
`ifdef SHIFT_SUB_DIV_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); z = 1'b0;
    end
`else
    if (b == 0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
`endif
  endtask

  // Launch from the current (post-edge) time; watch up to 20 edges.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int lat, output int bc,
                        output logic both);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bc = 0; both = 1'b0;
    q = 8'h00; r = 8'h00; z = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy && done) both = 1'b1;
      if (busy) bc++;
      if (done) begin
        lat = n; q = quotient; r = remainder; z = dbz;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== 19'd0) begin
      failures++;
      $display("FAIL reset: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy, done, dbz, quotient, remainder);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] q, r; logic z, both; int lat, bc;
    run_op(8'd100, 8'd7, q, r, z, lat, bc, both);
    checks++;
    if (lat !== 8 || bc !== 7 || both !== 1'b0) begin
      failures++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d both=%b want 8 7 0",
               lat, bc, both);
    end
    checks++;
    if (q !== 8'd14 || r !== 8'd2 || z !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want 14 2 0", q, r, z);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      failures++;
      $display("FAIL hold: got done=%b q=%0d r=%0d want 0 14 2",
               done, quotient, remainder);
    end
  endtask

  task automatic test_edges;
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd200};
    logic [7:0] vb [3] = '{8'd1, 8'd9, 8'd200};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] er [3] = '{8'd0, 8'd5, 8'd0};
    logic [7:0] q, r; logic z, both; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, z, lat, bc, both);
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat !== 8) begin
        failures++;
        $display("FAIL edge%0d: got q=%0d r=%0d dbz=%b lat=%0d want %0d %0d 0 8",
                 i, q, r, z, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_dbz;
    logic [7:0] q, r; logic z, both; int lat, bc;
    run_op(8'd37, 8'd0, q, r, z, lat, bc, both);
    checks++;
    if (lat !== 1 || bc !== 0) begin
      failures++;
      $display("FAIL dbz_timing: got lat=%0d busy=%0d want 1 0", lat, bc);
    end
    checks++;
    if (q !== 8'hFF || r !== 8'd37 || z !== 1'b1) begin
      failures++;
      $display("FAIL dbz_result: got q=%h r=%0d dbz=%b want ff 37 1", q, r, z);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || dbz !== 1'b1) begin
      failures++;
      $display("FAIL dbz_pulse: got done=%b dbz=%b want 0 1", done, dbz);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q, r; logic z, both; int lat, bc;
    logic [7:0] q1, r1; int lat1;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = 0; q1 = 8'h00; r1 = 8'h00;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        dividend = 8'd50; divisor = 8'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat1 = n; q1 = quotient; r1 = remainder;
        break;
      end
    end
    checks++;
    if (lat1 !== 8 || q1 !== 8'd14 || r1 !== 8'd2) begin
      failures++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want 8 14 2",
               lat1, q1, r1);
    end
    run_op(8'd50, 8'd3, q, r, z, lat, bc, both);
    checks++;
    if (lat !== 8 || q !== 8'd16 || r !== 8'd2) begin
      failures++;
      $display("FAIL back_to_back: got lat=%0d q=%0d r=%0d want 8 16 2",
               lat, q, r);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q, r; logic z, both; int lat, bc; int seen;
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h want 0",
               busy, done, dbz, quotient, remainder);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_abort: got %0d active cycles want 0", seen);
    end
    run_op(8'd9, 8'd2, q, r, z, lat, bc, both);
    checks++;
    if (lat !== 8 || q !== 8'd4 || r !== 8'd1 || z !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: got lat=%0d q=%0d r=%0d want 8 4 1",
               lat, q, r);
    end
  endtask

`ifdef SHIFT_SUB_DIV_SIGNED_EN
  task automatic test_signed;
    logic [7:0] va [3] = '{8'h9C, 8'd100, 8'h80};
    logic [7:0] vb [3] = '{8'd7, 8'hF9, 8'hFF};
    logic [7:0] eq [3] = '{8'hF2, 8'hF2, 8'h80};
    logic [7:0] er [3] = '{8'hFE, 8'h02, 8'h00};
    logic [7:0] q, r; logic z, both; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, z, lat, bc, both);
      checks++;
      if (q !== eq[i] || r !== er[i] || lat !== 8) begin
        failures++;
        $display("FAIL signed%0d: got q=%h r=%h lat=%0d want %h %h 8",
                 i, q, r, lat, eq[i], er[i]);
      end
    end
  endtask
`endif

  task automatic test_random;
    logic [7:0] a, b, q, r, mq, mr; logic z, mz, both; int lat, bc, el;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, mq, mr, mz);
      el = (b == 0) ? 1 : 8;
      run_op(a, b, q, r, z, lat, bc, both);
      checks++;
      if (q !== mq || r !== mr || z !== mz || lat !== el || both !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d %h/%h: got q=%h r=%h dbz=%b lat=%0d want %h %h %b %0d",
                 i, a, b, q, r, z, lat, mq, mr, mz, el);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_edges();
    test_dbz();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SUB_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
